// File: rtl/sigdelay_stream.sv
// -----------------------------------------------------------------------------
// sigdelay_stream
//
// Streaming delay line with a run-time programmable delay. Every accepted
// sample (en && in_valid) is written into a circular buffer of 2^A_WIDTH
// entries. The sample written delay_cur accepted samples earlier is read back
// and presented on dout one cycle later. Until the buffer holds delay_cur
// samples since reset (PRIME state), dout is forced to 0. This keeps stale RAM
// contents from reaching the output.
//
// Optional feature macro: SIGDELAY_ECHO_EN. When it is defined, the block adds
// the echo_out port, which carries the average of the input sample and its
// delayed copy.
//
// Parameters
//   A_WIDTH     buffer address width, depth = 2^A_WIDTH samples
//   D_WIDTH     sample width
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous reset, active low
//   en          global enable; when 0 all inputs are ignored and state holds
//   in_valid    din carries a sample
//   din         input sample
//   delay_load  load delay_in as the new delay (0 is clamped to 1)
//   delay_in    requested delay in samples
//   out_valid   one-cycle pulse, one per accepted sample
//   dout        delayed sample (0 while priming)
//   delay_cur   effective delay
//   busy        high while priming
//   echo_out    (SIGDELAY_ECHO_EN only) (din + dout) >> 1, aligned with dout
// -----------------------------------------------------------------------------
module sigdelay_stream #(
  parameter int A_WIDTH = 9,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  input  logic [D_WIDTH-1:0] din,
  input  logic               delay_load,
  input  logic [A_WIDTH-1:0] delay_in,
  output logic               out_valid,
  output logic [D_WIDTH-1:0] dout,
  output logic [A_WIDTH-1:0] delay_cur,
  output logic               busy
`ifdef SIGDELAY_ECHO_EN
  ,
  output logic [D_WIDTH-1:0] echo_out
`endif
);

  localparam int               DEPTH     = 1 << A_WIDTH;
  localparam logic [A_WIDTH-1:0] FILL_MAX  = '1;
  localparam logic [A_WIDTH-1:0] DELAY_MIN = A_WIDTH'(1);

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Sample storage. Writes and reads use a registered port and no reset, so
  // the array maps onto a dual-port block RAM.
  logic [D_WIDTH-1:0] mem_q [DEPTH];
  logic [D_WIDTH-1:0] rd_data_q;

  logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [A_WIDTH-1:0] fill_q, fill_d;
  logic [A_WIDTH-1:0] delay_q, delay_d;
  state_t             state_q, state_d;
  logic               out_valid_q;
  // Set when the sample now on the output was accepted during PRIME. Its RAM
  // read data is not meaningful and must be hidden.
  logic               mask_q;

  logic               accept;
  logic               load;
  logic [A_WIDTH-1:0] rd_addr;
  logic [A_WIDTH-1:0] delay_clamped;

  assign accept        = en & in_valid;
  assign load          = en & delay_load;
  // The subtraction wraps modulo the depth. Because delay_q >= 1, rd_addr
  // never equals wr_ptr_q. A delay of 2^A_WIDTH-1 reads the oldest slot.
  assign rd_addr       = wr_ptr_q - delay_q;
  assign delay_clamped = (delay_in == '0) ? DELAY_MIN : delay_in;

  // Next-state logic
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    delay_d  = delay_q;
    state_d  = state_q;

    if (accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end
      // The exit from PRIME is evaluated against the post-increment fill.
      if ((state_q == ST_PRIME) && (fill_d >= delay_q)) begin
        state_d = ST_RUN;
      end
    end

    // A load decides the state from the new delay. A sample accepted in the
    // same cycle has already used the old delay and the old state.
    if (load) begin
      delay_d = delay_clamped;
      state_d = (fill_d >= delay_clamped) ? ST_RUN : ST_PRIME;
    end
  end

  // Control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      delay_q     <= DELAY_MIN;
      state_q     <= ST_PRIME;
      out_valid_q <= 1'b0;
      mask_q      <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      delay_q     <= delay_d;
      state_q     <= state_d;
      out_valid_q <= accept;
      if (accept) begin
        mask_q <= (state_q == ST_PRIME);
      end
    end
  end

  // RAM ports
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= din;
      rd_data_q       <= mem_q[rd_addr];
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = mask_q ? '0 : rd_data_q;
  assign delay_cur = delay_q;
  assign busy      = (state_q == ST_PRIME);

`ifdef SIGDELAY_ECHO_EN
  // The input sample is held so that it lines up with its delayed partner.
  // That partner appears on dout in the same cycle.
  logic [D_WIDTH-1:0] din_q;
  logic [D_WIDTH:0]   echo_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      din_q <= '0;
    end else if (accept) begin
      din_q <= din;
    end
  end

  assign echo_sum = {1'b0, din_q} + {1'b0, dout};
  assign echo_out = echo_sum[D_WIDTH:1];
`endif

endmodule

// File: tb/tb_sigdelay_stream.sv
// -----------------------------------------------------------------------------
// tb_sigdelay_stream: self-checking bench for sigdelay_stream (default sizes
// A_WIDTH=9, D_WIDTH=8). A behavioural model keeps the full sample history
// since reset. It predicts each output as history[n - delay], or 0 while
// priming. Predictions go into a queue when a sample is driven. They are
// popped and compared when the DUT presents the output.
// -----------------------------------------------------------------------------
module tb_sigdelay_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       in_valid;
  logic [7:0] din;
  logic       delay_load;
  logic [8:0] delay_in;
  logic       out_valid;
  logic [7:0] dout;
  logic [8:0] delay_cur;
  logic       busy;
`ifdef SIGDELAY_ECHO_EN
  logic [7:0] echo_out;
`endif

  sigdelay_stream #(.A_WIDTH(9), .D_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in_valid   (in_valid),
    .din        (din),
    .delay_load (delay_load),
    .delay_in   (delay_in),
    .out_valid  (out_valid),
    .dout       (dout),
    .delay_cur  (delay_cur),
    .busy       (busy)
`ifdef SIGDELAY_ECHO_EN
    ,
    .echo_out   (echo_out)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int  hist [8192];
  int  n_acc;
  int  m_fill;
  int  m_delay;
  bit  m_prime;

  typedef struct {
    int dout;
    int echo;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    bit e;
    bit iv;
    int d;
    bit ld;
    int dl;
    bit x_valid;
    int x_dout;
    bit x_busy;
    int x_delay;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input bit e, input bit iv, input int d, input bit ld,
                              input int dl, input bit xv, input int xd,
                              input bit xb, input int xdl);
    vec_t v;
    v.e = e; v.iv = iv; v.d = d; v.ld = ld; v.dl = dl;
    v.x_valid = xv; v.x_dout = xd; v.x_busy = xb; v.x_delay = xdl;
    return v;
  endfunction

  task automatic model_reset();
    n_acc   = 0;
    m_fill  = 0;
    m_delay = 1;
    m_prime = 1'b1;
    sbq.delete();
  endtask

  // Drive one cycle of inputs, update the model, clock, then check outputs.
  task automatic step(input bit e, input bit iv, input int d, input bit ld, input int dl);
    bit   acc;
    bit   lo;
    int   dv;
    int   dlv;
    exp_t x;
    dv  = d & 255;
    dlv = dl & 511;
    en = e; in_valid = iv; din = dv[7:0]; delay_load = ld; delay_in = dlv[8:0];
    acc = e && iv;
    lo  = e && ld;
    if (acc) begin
      if (m_prime || (n_acc - m_delay) < 0) x.dout = 0;
      else x.dout = hist[n_acc - m_delay];
      x.echo = (dv + x.dout) / 2;
      sbq.push_back(x);
      hist[n_acc] = dv;
      n_acc++;
      if (m_fill < 511) m_fill++;
      if (m_prime && m_fill >= m_delay) m_prime = 1'b0;
    end
    if (lo) begin
      m_delay = (dlv == 0) ? 1 : dlv;
      m_prime = (m_fill < m_delay);
    end
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      x = sbq.pop_front();
      chk("sb_valid", int'(out_valid), 1);
      if (out_valid) begin
        chk("sb_dout", int'(dout), x.dout);
`ifdef SIGDELAY_ECHO_EN
        chk("sb_echo", int'(echo_out), x.echo);
`endif
      end
    end else begin
      chk("sb_no_valid", int'(out_valid), 0);
    end
    chk("sb_busy", int'(busy), int'(m_prime));
    chk("sb_delay", int'(delay_cur), m_delay);
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; in_valid = 1'b0; din = '0; delay_load = 1'b0; delay_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dout", int'(dout), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_delay", int'(delay_cur), 1);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    // Table: load delay 4, then ramp 1..8. Expected dout 0,0,0,0,1,2,3,4.
    // busy falls after the 4th sample.
    vecs[0] = mk(1, 0, 0, 1, 4, 0, 0, 1, 4);
    for (int k = 1; k <= 8; k++) begin
      vecs[k] = mk(1, 1, k, 0, 0, 1, (k <= 4) ? 0 : k - 4, (k < 4), 4);
    end
    vecs[9] = mk(1, 0, 0, 0, 0, 0, 0, 0, 4);

    model_reset();
    do_reset();

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].e, vecs[i].iv, vecs[i].d, vecs[i].ld, vecs[i].dl);
      chk($sformatf("tbl%0d_valid", i), int'(out_valid), int'(vecs[i].x_valid));
      if (vecs[i].x_valid) chk($sformatf("tbl%0d_dout", i), int'(dout), vecs[i].x_dout);
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(vecs[i].x_busy));
      chk($sformatf("tbl%0d_delay", i), int'(delay_cur), vecs[i].x_delay);
    end

    // Load 0: the DUT clamps it to 1, so the output lags by one sample.
    step(1, 0, 0, 1, 0);
    chk("load0_delay", int'(delay_cur), 1);
    step(1, 1, 20, 0, 0);
    chk("lag1_first", int'(dout), 8);
    for (int k = 21; k < 25; k++) begin
      step(1, 1, k, 0, 0);
      chk("lag1_dout", int'(dout), k - 1);
    end

    // Full depth: delay 511 with 1100 counter samples, across two wraps.
    do_reset();
    step(1, 0, 0, 1, 511);
    for (int k = 0; k < 1100; k++) begin
      step(1, 1, k, 0, 0);
    end
    chk("deep_last", int'(dout), (1099 - 511) & 255);
    chk("deep_busy", int'(busy), 0);

    // Load while running: 50 stays RUN, 200 goes back to PRIME.
    do_reset();
    for (int k = 0; k < 100; k++) step(1, 1, k + 1, 0, 0);
    step(1, 0, 0, 1, 50);
    chk("load50_busy", int'(busy), 0);
    step(1, 1, 101, 0, 0);
    chk("load50_dout", int'(dout), 51);
    for (int k = 102; k < 120; k++) step(1, 1, k, 0, 0);
    step(1, 1, 120, 1, 200);
    chk("load200_busy", int'(busy), 1);
    for (int k = 121; k < 210; k++) step(1, 1, k, 0, 0);
    chk("load200_run", int'(busy), 0);

    // An en=0 gap of 7 cycles ignores both the sample and the load.
    for (int k = 0; k < 7; k++) begin
      step(0, 1, 77, 1, 3);
      chk("gap_no_valid", int'(out_valid), 0);
    end
    for (int k = 210; k < 220; k++) step(1, 1, k, 0, 0);
    chk("gap_resume_delay", int'(delay_cur), 200);

    // Reset asserted in mid-stream, away from the clock edge.
    step(1, 0, 0, 1, 1);
    step(1, 1, 8'hA5, 0, 0);
    step(1, 1, 8'h5A, 0, 0);
    chk("pre_rst_dout", int'(dout), 8'hA5);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_dout", int'(dout), 0);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_busy", int'(busy), 1);
    chk("mid_rst_delay", int'(delay_cur), 1);
    en = 1'b0; in_valid = 1'b0; delay_load = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int k = 0; k < 6; k++) step(1, 1, 30 + k, 0, 0);

    // Random mix: en, in_valid, loads, and same-cycle load plus sample.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, int'($urandom_range(0, 255)),
           $urandom_range(0, 39) == 0, int'($urandom_range(0, 40)));
    end

`ifdef SIGDELAY_ECHO_EN
    // Echo: delay 2, din 200,100,255,255 -> echo 100,50,227,177.
    do_reset();
    step(1, 0, 0, 1, 2);
    step(1, 1, 200, 0, 0); chk("echo0", int'(echo_out), 100);
    step(1, 1, 100, 0, 0); chk("echo1", int'(echo_out), 50);
    step(1, 1, 255, 0, 0); chk("echo2", int'(echo_out), 227);
    step(1, 1, 255, 0, 0); chk("echo3", int'(echo_out), 177);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sigdelay_stream.md
# sigdelay_stream

Parametrised streaming delay line, the successor to the fixed-offset signal delay block in the signal-generator path. Each accepted input sample is written into an internal circular buffer of 2^A_WIDTH entries and re-emitted exactly `delay_cur` accepted samples later, with one cycle of latency. The delay is run-time programmable through a load strobe, and the block tracks buffer fill so that it never emits stale RAM contents. It sits between the sine/ROM generator (or ADC capture) and the output/scope stage.

## Interface
- `A_WIDTH`, default 9: buffer address width; depth = 2^A_WIDTH samples.
- `D_WIDTH`, default 8: sample width.
- `clk`  in  1: single clock; all state on the rising edge.
- `rst`  in  1: asynchronous, active-low reset (asserted at 0).
- `en`  in  1: global enable; when 0, `in_valid` and `delay_load` are ignored and all state holds.
- `in_valid`  in  1: `din` carries a sample this cycle.
- `din`  in  D_WIDTH: input sample.
- `delay_load`  in  1: load `delay_in` as the new delay.
- `delay_in`  in  A_WIDTH: requested delay in samples.
- `out_valid`  out  1: `dout` valid this cycle.
- `dout`  out  D_WIDTH: delayed sample.
- `delay_cur`  out  A_WIDTH: effective delay.
- `busy`  out  1: high in PRIME state (buffer not yet holding `delay_cur` samples).

## Operation
- Storage: 2^A_WIDTH x D_WIDTH dual-port RAM with a synchronous read. `wr_ptr` (A_WIDTH bits) advances by 1 per accepted sample and wraps naturally. `rd_addr = wr_ptr - delay_cur` (mod 2^A_WIDTH).
- Accepted sample: `en && in_valid`. Write `din` at `wr_ptr`, read at `rd_addr` in the same cycle. Because `delay_cur >= 1`, the two addresses never collide.
- Delay clamp: `delay_in == 0` loads 1. The maximum is 2^A_WIDTH-1, where the read targets the oldest entry (`wr_ptr+1`).
- `fill`: count of accepted samples since reset, saturating at 2^A_WIDTH-1.
- FSM:
  - PRIME: `dout` forced to 0 for accepted samples while `fill < delay_cur`. Go to RUN once `fill >= delay_cur`, evaluated after the increment.
  - RUN: `dout` is the RAM read data.
- Delay load (`en && delay_load`): `delay_cur` updates the next cycle. `fill` is kept. Next state is RUN if `fill >= new delay`, else PRIME.
- Load in the same cycle as an accepted sample: that sample uses the old `delay_cur` and old state. The new delay applies from the next accepted sample.
- Arithmetic is modulo 2^A_WIDTH with no overflow flags. `fill` never wraps.

## Timing
- Reset values: `dout`=0, `out_valid`=0, `busy`=1, `delay_cur`=1, `wr_ptr`=0, `fill`=0, state PRIME.
- Latency: `out_valid` is high exactly one cycle after each accepted sample, and `dout` is registered in the same cycle. No backpressure: output is one-for-one with accepted input.
- `busy` changes one cycle after the event that changes state.
- `en`=0 mid-stream: no `out_valid` pulses. Pointers, `fill`, FSM and `delay_cur` freeze, and the stream resumes seamlessly.
- Reset asserted mid-operation: all registers take their reset values immediately (asynchronously). RAM contents are not cleared, but PRIME masks them.

## Configuration
- `SIGDELAY_ECHO_EN` defined:
  - Adds output `echo_out` (D_WIDTH).
  - `echo_out = (din + delayed) >> 1`, computed in D_WIDTH+1 bits, where `delayed` is the value presented on `dout` (0 in PRIME).
  - Registered with the same one-cycle latency and qualified by `out_valid`. Reset value 0.
- `SIGDELAY_ECHO_EN` undefined: the port and adder are absent, and all other behaviour is identical.

## Test plan
- Reset, then feed ramp 1,2,3,… with `delay_in`=4 loaded before the first sample:
  - `dout`: 0,0,0,0,1,2,3,….
  - `busy` falls one cycle after the 4th accepted sample.
- `delay_in`=0 load: `delay_cur` reads 1 and `dout` lags `din` by one sample.
- Full depth (A_WIDTH=9): `delay_in`=511, stream 1100 samples of a counter → `dout` = sample n-511 across two pointer wraps, with no glitch.
- In RUN with `fill`=100, load delay 50 → stays RUN (`busy`=0) and output jumps to n-50. Then load 200 → PRIME, zeros until `fill`=200.
- Toggle `en`=0 for 7 cycles mid-stream and `rst`=0 mid-stream:
  - `en`=0: no `out_valid` during the gap, and the sequence continues unbroken.
  - Reset: outputs go to 0 immediately, `delay_cur`=1, `busy`=1.
- With `SIGDELAY_ECHO_EN`: delay 2, `din`=200,100,255,255 → `echo_out`=100,50,227,177.
